// File: rtl/seq_display_pkg.sv
// Shared constants, digit-index type and helpers for the seq_display scanner.
package seq_display_pkg;

  localparam int unsigned DEFAULT_DIV = 100000;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  typedef enum logic [1:0] {
    DIG_VAL_ONES = 2'd0,
    DIG_VAL_TENS = 2'd1,
    DIG_CNT_ONES = 2'd2,
    DIG_CNT_TENS = 2'd3
  } digit_t;

  function automatic digit_t next_digit(input digit_t d);
    case (d)
      DIG_VAL_ONES: return DIG_VAL_TENS;
      DIG_VAL_TENS: return DIG_CNT_ONES;
      DIG_CNT_ONES: return DIG_CNT_TENS;
      default:      return DIG_VAL_ONES;
    endcase
  endfunction

  // Returns {tens, ones} of a 0..63 value.
  function automatic logic [7:0] split_value(input logic [5:0] v);
    logic [5:0] t;
    logic [5:0] o;
    t = v / 6'd10;
    o = v % 6'd10;
    return {t[3:0], o[3:0]};
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low {g,f,e,d,c,b,a} segment pattern, with blanking.
module seg7_decoder
  import seq_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seq_display.sv
// Captures sequence terms and a 0..99 sample count, and scans them onto a
// four-digit multiplexed seven-segment display.
module seq_display
  import seq_display_pkg::*;
#(
  parameter int unsigned DIV = DEFAULT_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [5:0] in_data,
  input  logic       freeze,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam logic [19:0] DIV_LAST = 20'(DIV - 1);

  logic [5:0]  value;
  logic [3:0]  cnt_ones;
  logic [3:0]  cnt_tens;
  logic [19:0] divider;
  digit_t      idx;

  logic [3:0]  val_ones;
  logic [3:0]  val_tens;
  logic [3:0]  cur_digit;
  logic        cur_blank;
  logic [6:0]  cur_seg;

  always_comb {val_tens, val_ones} = split_value(value);

  always_comb begin
    cur_digit = val_ones;
    cur_blank = 1'b0;
    case (idx)
      DIG_VAL_ONES: cur_digit = val_ones;
      DIG_VAL_TENS: begin cur_digit = val_tens; cur_blank = (val_tens == 4'd0); end
      DIG_CNT_ONES: cur_digit = cnt_ones;
      DIG_CNT_TENS: begin cur_digit = cnt_tens; cur_blank = (cnt_tens == 4'd0); end
      default:      cur_digit = val_ones;
    endcase
  end

  seg7_decoder u_dec (
    .digit (cur_digit),
    .blank (cur_blank),
    .seg   (cur_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value    <= '0;
      cnt_ones <= '0;
      cnt_tens <= '0;
      divider  <= '0;
      idx      <= DIG_VAL_ONES;
      an       <= '1;
      seg      <= SEG_BLANK;
      dp       <= 1'b1;
    end else begin
      if (in_valid && !freeze) begin
        value <= in_data;
        if (cnt_ones == 4'd9) begin
          cnt_ones <= '0;
          cnt_tens <= (cnt_tens == 4'd9) ? '0 : cnt_tens + 4'd1;
        end else begin
          cnt_ones <= cnt_ones + 4'd1;
        end
      end
      // Each wrap latches the digit for idx onto the pins, then moves idx on,
      // so the first lit digit after reset is digit 0.
      if (divider == DIV_LAST) begin
        divider <= '0;
        idx     <= next_digit(idx);
        an      <= ~(4'b0001 << idx);
        seg     <= cur_seg;
        dp      <= (idx != DIG_CNT_ONES);
      end else begin
        divider <= divider + 20'd1;
      end
    end
  end

endmodule

// File: tb/tb_seq_display.sv
// Randomized bench for seq_display against a cycle-level arithmetic model.
module tb_seq_display;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [5:0] in_data;
  logic       freeze;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  int         edges;
  int         m_val;
  int         m_cnt;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  always #5 clk = ~clk;

  seq_display #(.DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .freeze   (freeze),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp_v);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d, input bit blank);
    logic [6:0] codes [10];
    codes = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    if (blank) return 7'b1111111;
    return codes[d];
  endfunction

  task automatic model_reset();
    edges   = 0;
    m_val   = 0;
    m_cnt   = 0;
    exp_an  = 4'b1111;
    exp_seg = 7'b1111111;
    exp_dp  = 1'b1;
  endtask

  task automatic check_outputs(input string where);
    chk({where, ".an"},  int'(an),  int'(exp_an));
    chk({where, ".seg"}, int'(seg), int'(exp_seg));
    chk({where, ".dp"},  int'(dp),  int'(exp_dp));
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic cycle(input bit v, input logic [5:0] d, input bit f);
    int k;
    in_valid = v;
    in_data  = d;
    freeze   = f;
    @(posedge clk);
    edges++;
    if (edges % DIV == 0) begin
      k       = ((edges / DIV) - 1) % 4;
      exp_an  = ~(4'b0001 << k);
      exp_dp  = (k != 2);
      case (k)
        0:       exp_seg = seg_of(m_val % 10, 1'b0);
        1:       exp_seg = seg_of(m_val / 10, (m_val / 10) == 0);
        2:       exp_seg = seg_of(m_cnt % 10, 1'b0);
        default: exp_seg = seg_of(m_cnt / 10, (m_cnt / 10) == 0);
      endcase
    end
    if (v && !f) begin
      m_val = int'(d);
      m_cnt = (m_cnt + 1) % 100;
    end
    #1;
    check_outputs("scan");
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) cycle(1'b0, 6'd0, 1'b0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset(input bit pending_valid);
    in_valid = pending_valid;
    in_data  = 6'd55;
    rst      = 1'b1;
    #1;
    model_reset();
    check_outputs("rst_async");
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst      = 1'b0;
  endtask

  initial begin
    int found;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    freeze   = 1'b0;
    model_reset();
    #2;
    check_outputs("rst_init");
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Idle scan: tens blank, "0" on ones digits, dp only on digit 2.
    idle(8 * DIV);

    cycle(1'b1, 6'd63, 1'b0);
    idle(4 * DIV + 2);
    cycle(1'b1, 6'd7, 1'b0);
    idle(4 * DIV + 2);

    // 100 back-to-back captures wraps the count to 0, then one more.
    do_reset(1'b0);
    for (int i = 0; i < 100; i++) cycle(1'b1, 6'($urandom_range(0, 63)), 1'b0);
    idle(4 * DIV + 2);
    cycle(1'b1, 6'd40, 1'b0);
    idle(4 * DIV + 2);

    // Freeze suppresses capture but not scanning.
    cycle(1'b1, 6'd5, 1'b1);
    idle(3);
    cycle(1'b1, 6'd9, 1'b1);
    idle(4 * DIV + 2);
    cycle(1'b1, 6'd9, 1'b0);
    idle(4 * DIV + 2);

    // Reset in the middle of digit 2 with a capture pending.
    cycle(1'b1, 6'd42, 1'b0);
    found = 0;
    for (int i = 0; i < 8 * DIV && found == 0; i++) begin
      if (exp_an == 4'b1011) found = 1;
      else idle(1);
    end
    chk("reach_an_1011", found, 1);
    do_reset(1'b1);
    idle(8 * DIV);

    // Random traffic, including freeze and bursts.
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 99) < 40), 6'($urandom_range(0, 63)),
            1'($urandom_range(0, 99) < 20));
      if ($urandom_range(0, 999) == 0) do_reset($urandom_range(0, 1) == 1);
    end
    idle(4 * DIV);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
